// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/shifted-branch) with a 2-entry skid buffer.
// Optional macro IMM_EXT_CNT_EN adds the ext_cnt output-transfer counter port.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [31:0]      ext_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   or_imm_q, or_imm_d, sr_imm_q, sr_imm_d;
    logic [TAG_W-1:0]   or_tag_q, or_tag_d, sr_tag_q, sr_tag_d;
    logic [OUT_W-1:0]   sext_imm;
    logic [OUT_W-1:0]   ext_imm;
    logic               accept;

    // Extension happens on the way in so only finished results are buffered.
    always_comb begin
        sext_imm = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
        ext_imm  = sext_imm;
        case (in_mode)
            2'b00:   ext_imm = sext_imm;
            2'b01:   ext_imm = {{(OUT_W-IN_W){1'b0}}, in_imm};
            2'b10:   ext_imm = {in_imm, {(OUT_W-IN_W){1'b0}}};
            default: ext_imm = sext_imm << SHIFT;
        endcase
    end

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign out_imm   = or_imm_q;
    assign out_tag   = or_tag_q;

    always_comb begin
        state_d  = state_q;
        or_imm_d = or_imm_q;
        or_tag_d = or_tag_q;
        sr_imm_d = sr_imm_q;
        sr_tag_d = sr_tag_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    or_imm_d = ext_imm;
                    or_tag_d = in_tag;
                    state_d  = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && out_ready) begin
                    or_imm_d = ext_imm;
                    or_tag_d = in_tag;
                end else if (accept) begin
                    // Consumer stalled: park the new beat behind the held one.
                    sr_imm_d = ext_imm;
                    sr_tag_d = in_tag;
                    state_d  = S_FULL;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    or_imm_d = sr_imm_q;
                    or_tag_d = sr_tag_q;
                    state_d  = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            or_imm_q <= '0;
            or_tag_q <= '0;
            sr_imm_q <= '0;
            sr_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            or_imm_q <= or_imm_d;
            or_tag_q <= or_tag_d;
            sr_imm_q <= sr_imm_d;
            sr_tag_q <= sr_tag_d;
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ext_cnt = cnt_q;
`endif

endmodule
